stream_frame_ctrl: RTL and testbench
====================================

# stream_frame_ctrl

Frame sequencer for the line-buffered blur stream accelerators. It sits between the pixel source, the accelerator and the output sink. It issues the accelerator start pulse and gates both stream handshakes so exactly one IMG_W×IMG_H frame enters and leaves. It marks end-of-line and end-of-frame on the output and raises a stop pulse when the frame has drained. A stall watchdog flags a hung pipeline.

## Interface
- IMG_W, 256, pixels per row (≥2)
- IMG_H, 256, rows per frame (≥2)
- DW, 8, pixel width
- TIMEOUT, 4096, consecutive no-progress cycles before error (≥2)

- clk  in  1  clock
- reset  in  1  synchronous, active-high
- frame_start  in  1  request one frame; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- acc_start  out  1  one-cycle start pulse to the accelerator
- src_valid  in  1  source pixel valid
- src_ready  out  1  ready to source
- acc_in_valid  out  1  valid to accelerator input
- acc_in_ready  in  1  accelerator input ready
- acc_out_valid  in  1  accelerator output valid
- acc_out_data  in  DW  accelerator output pixel
- acc_out_ready  out  1  ready to accelerator output
- snk_valid, snk_data  out  1, DW  pixel to sink
- snk_ready  in  1  sink ready
- snk_eol  out  1  qualifies snk_valid: last pixel of a row
- snk_eof  out  1  qualifies snk_valid: last pixel of the frame
- stop  out  1  one-cycle frame-complete pulse
- err  out  1  sticky watchdog error

## Operation
- States: IDLE, START, RUN, DONE, ERR.
- IDLE: frame_start=1 moves to START. This clears err, in_col/in_row, out_col/out_row and the stall counter.
- START: acc_start=1 for exactly one cycle, then RUN. All gates stay closed in START.
- RUN, input gate: in_open = (in_cnt < IMG_W·IMG_H).
  - acc_in_valid = src_valid & in_open.
  - src_ready = acc_in_ready & in_open. Both are combinational.
  - Each src_valid&src_ready beat advances in_col. in_col wraps at IMG_W-1 and increments in_row.
- RUN, output gate: out_open = (out_cnt < IMG_W·IMG_H).
  - snk_valid = acc_out_valid & out_open.
  - acc_out_ready = snk_ready & out_open.
  - snk_data = acc_out_data.
  - Each snk_valid&snk_ready beat advances out_col/out_row with the same wrap rule.
- snk_eol = (out_col == IMG_W-1). snk_eof = snk_eol & (out_row == IMG_H-1). Both are combinational from the counters.
- The final output beat (eof handshake) moves to DONE. The input count has necessarily completed by then. If it has not, this is an accelerator fault: go to ERR instead.
- DONE: stop=1 for one cycle, then IDLE.
- Watchdog:
  - In RUN, the stall counter increments on every cycle with no input beat and no output beat.
  - It clears on any beat.
  - When it reaches TIMEOUT-1 with no beat, go to ERR.
- ERR: all gates closed and err=1. frame_start re-enters START and clears err. Otherwise ERR holds.
- frame_start is ignored outside IDLE and ERR.
- Counter widths: $clog2(IMG_W) and $clog2(IMG_H); stall counter $clog2(TIMEOUT)+1.

## Timing
- Reset (synchronous, high for ≥1 cycle):
  - Forces IDLE and clears all counters.
  - Outputs: busy=0, acc_start=0, stop=0, err=0.
  - All valid/ready outputs are 0.
- Reset mid-frame aborts immediately. Gates close in the cycle after the reset edge. No stop pulse is generated.
- Latency:
  - frame_start high at edge N puts acc_start high during cycle N+1.
  - Gates open from cycle N+2.
  - The last output handshake at edge M puts stop high during cycle M+1; busy falls at cycle M+2.
- Handshake gating adds zero cycles. A beat counts only on the edge where valid and ready are both high.
- Input and output beats in the same cycle are both counted.
- Once in_cnt reaches the full frame, src_ready and acc_in_valid stay low for the rest of the frame. Excess source data is held back, not dropped.
- snk_eol and snk_eof remain stable while snk_valid is held without ready.

## Test plan
- IMG_W=4, IMG_H=3, with source, accelerator and sink always ready:
  - acc_start pulses once; 12 input and 12 output beats occur.
  - snk_eol is high on beats 4, 8 and 12; snk_eof only on beat 12.
  - stop pulses the cycle after beat 12.
- Random snk_ready and src_valid stalls (1–32 cycles, 50% probability), 256×256 frame:
  - Output data matches the expected sequence; exactly 65536 output beats; one stop pulse.
  - snk_data never changes while snk_valid=1 and snk_ready=0.
- Source offers 20 pixels for a 4×3 frame: src_ready is low after beat 12 and the remaining 8 pixels are never accepted.
- TIMEOUT=16, acc_out_valid stuck at 0 after 5 output beats: err=1 exactly 16 stall cycles after the last beat and all gates close. A subsequent frame_start clears err and pulses acc_start.
- Reset asserted at output beat 6 of 12: the next cycle shows busy=0 and gates low, with no stop pulse. The next frame completes normally with correct eol/eof positions.
- frame_start pulsed repeatedly during RUN: no extra acc_start pulse and counters unaffected.

Source files
------------

// File: rtl/stream_frame_ctrl_if.sv
// Stream handshake bundle between the frame controller, pixel source, accelerator and sink.
// The master view is the controller; the slave view is its surroundings.
interface stream_frame_ctrl_if #(
    parameter int DW = 8
);
    logic          src_valid;
    logic          src_ready;
    logic          acc_in_valid;
    logic          acc_in_ready;
    logic          acc_out_valid;
    logic [DW-1:0] acc_out_data;
    logic          acc_out_ready;
    logic          snk_valid;
    logic [DW-1:0] snk_data;
    logic          snk_ready;
    logic          snk_eol;
    logic          snk_eof;

    modport master (
        input  src_valid, acc_in_ready, acc_out_valid, acc_out_data, snk_ready,
        output src_ready, acc_in_valid, acc_out_ready, snk_valid, snk_data, snk_eol, snk_eof
    );

    modport slave (
        output src_valid, acc_in_ready, acc_out_valid, acc_out_data, snk_ready,
        input  src_ready, acc_in_valid, acc_out_ready, snk_valid, snk_data, snk_eol, snk_eof
    );
endinterface

// File: rtl/stream_frame_ctrl.sv
// Frame sequencer: starts the accelerator, admits exactly one IMG_W x IMG_H frame on both
// stream sides, tags end-of-line/end-of-frame, pulses stop on drain and watches for stalls.
module stream_frame_ctrl #(
    parameter int IMG_W   = 256,
    parameter int IMG_H   = 256,
    parameter int DW      = 8,
    parameter int TIMEOUT = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    output logic                busy,
    output logic                acc_start,
    output logic                stop,
    output logic                err,
    stream_frame_ctrl_if.master sif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = $clog2(TIMEOUT) + 1;

    localparam logic [CW-1:0] COL_LAST   = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST   = RW'(IMG_H - 1);
    localparam logic [SW-1:0] STALL_LAST = SW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] in_col_r;
    logic [RW-1:0] in_row_r;
    logic          in_done_r;
    logic [CW-1:0] out_col_r;
    logic [RW-1:0] out_row_r;
    logic [SW-1:0] stall_r;

    logic in_open_s;
    logic out_open_s;
    logic in_beat_s;
    logic out_beat_s;
    logic in_last_s;
    logic start_s;
    logic progress_s;

    // Counters wrap back to zero on the final pixel, so a separate flag remembers a full input frame.
    assign in_open_s  = (state_r == S_RUN) && !in_done_r;
    assign out_open_s = (state_r == S_RUN);

    assign sif.acc_in_valid  = sif.src_valid & in_open_s;
    assign sif.src_ready     = sif.acc_in_ready & in_open_s;
    assign sif.snk_valid     = sif.acc_out_valid & out_open_s;
    assign sif.acc_out_ready = sif.snk_ready & out_open_s;
    assign sif.snk_data      = DW'(sif.acc_out_data);

    assign in_beat_s  = sif.src_valid & sif.src_ready;
    assign out_beat_s = sif.snk_valid & sif.snk_ready;
    assign progress_s = in_beat_s | out_beat_s;
    assign in_last_s  = (in_col_r == COL_LAST) && (in_row_r == ROW_LAST);

    assign sif.snk_eol = (out_col_r == COL_LAST);
    assign sif.snk_eof = sif.snk_eol && (out_row_r == ROW_LAST);

    assign start_s = frame_start && ((state_r == S_IDLE) || (state_r == S_ERR));

    assign busy      = (state_r != S_IDLE);
    assign acc_start = (state_r == S_START);
    assign stop      = (state_r == S_DONE);
    assign err       = (state_r == S_ERR);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (start_s) begin
                    state_nx_s = S_START;
                end else begin
                    state_nx_s = S_IDLE;
                end
            end
            S_START: state_nx_s = S_RUN;
            S_RUN: begin
                if (out_beat_s && sif.snk_eof) begin
                    // Output cannot legitimately finish before the whole input frame went in.
                    if (in_done_r || (in_beat_s && in_last_s)) begin
                        state_nx_s = S_DONE;
                    end else begin
                        state_nx_s = S_ERR;
                    end
                end else if (!progress_s && (stall_r == STALL_LAST)) begin
                    state_nx_s = S_ERR;
                end else begin
                    state_nx_s = S_RUN;
                end
            end
            S_DONE: state_nx_s = S_IDLE;
            S_ERR: begin
                if (start_s) begin
                    state_nx_s = S_START;
                end else begin
                    state_nx_s = S_ERR;
                end
            end
            default: state_nx_s = S_IDLE;
        endcase
    end

    // Pixel position counters and stall watchdog; all cleared whenever a frame is launched.
    always_ff @(posedge clk) begin
        if (reset || start_s) begin
            in_col_r  <= {CW{1'b0}};
            in_row_r  <= {RW{1'b0}};
            in_done_r <= 1'b0;
            out_col_r <= {CW{1'b0}};
            out_row_r <= {RW{1'b0}};
            stall_r   <= {SW{1'b0}};
        end else begin
            if (in_beat_s) begin
                if (in_col_r == COL_LAST) begin
                    in_col_r <= {CW{1'b0}};
                    in_row_r <= (in_row_r == ROW_LAST) ? {RW{1'b0}} : in_row_r + 1'b1;
                end else begin
                    in_col_r <= in_col_r + 1'b1;
                end
                if (in_last_s) begin
                    in_done_r <= 1'b1;
                end
            end
            if (out_beat_s) begin
                if (out_col_r == COL_LAST) begin
                    out_col_r <= {CW{1'b0}};
                    out_row_r <= (out_row_r == ROW_LAST) ? {RW{1'b0}} : out_row_r + 1'b1;
                end else begin
                    out_col_r <= out_col_r + 1'b1;
                end
            end
            if ((state_r != S_RUN) || progress_s) begin
                stall_r <= {SW{1'b0}};
            end else begin
                stall_r <= stall_r + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_stream_frame_ctrl.sv
// Bench for stream_frame_ctrl: a queue-based accelerator and frame model driven by
// randomised source/sink stalls, with directed abort, overflow and watchdog scenarios.
module tb_stream_frame_ctrl;
    localparam int W         = 4;
    localparam int H         = 3;
    localparam int N         = W * H;
    localparam int TO        = 16;
    localparam int SRC_PIX   = 20;
    localparam int ACC_DEPTH = 4;

    logic clk;
    logic reset;
    logic frame_start;
    logic busy;
    logic acc_start;
    logic stop;
    logic err;

    stream_frame_ctrl_if #(.DW(8)) sif ();

    stream_frame_ctrl #(
        .IMG_W(W), .IMG_H(H), .DW(8), .TIMEOUT(TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .frame_start(frame_start),
        .busy(busy),
        .acc_start(acc_start),
        .stop(stop),
        .err(err),
        .sif(sif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] acc_q[$];
    int   in_idx;
    int   out_idx;
    int   nobeat;
    bit   m_stall;
    bit   m_noise;
    int   m_stuck;
    int   m_abort;
    int   src_left;
    int   snk_left;
    bit   src_cool;
    bit   snk_cool;
    bit   prev_hold;
    logic [7:0] prev_data;
    logic prev_eol;
    logic prev_eof;

    function automatic logic [7:0] pix(input int i);
        logic [31:0] v;
        v = i * 37 + 11;
        return v[7:0] ^ 8'hA5;
    endfunction

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chki(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive_all(input logic v);
        sif.src_valid     = v;
        sif.acc_in_ready  = v;
        sif.acc_out_valid = v;
        sif.acc_out_data  = 8'h00;
        sif.snk_ready     = v;
    endtask

    // Inputs are all offered high, so any open gate would show up here.
    task automatic chk_closed(input string tag);
        chk1({tag, "_src_ready"}, sif.src_ready, 1'b0);
        chk1({tag, "_acc_in_valid"}, sif.acc_in_valid, 1'b0);
        chk1({tag, "_snk_valid"}, sif.snk_valid, 1'b0);
        chk1({tag, "_acc_out_ready"}, sif.acc_out_ready, 1'b0);
    endtask

    // Stall streaks of 1..5 cycles, always followed by one free cycle.
    task automatic roll(inout int left, inout bit cool, output bit st);
        st = 1'b0;
        if (left > 0) begin
            left--;
            st   = 1'b1;
            cool = (left == 0);
        end else if (cool) begin
            cool = 1'b0;
        end else if (m_stall && ($urandom_range(0, 1) == 1)) begin
            left = $urandom_range(0, 4);
            st   = 1'b1;
            cool = (left == 0);
        end
    endtask

    task automatic start_frame(input bit from_err);
        frame_start = 1'b1;
        drive_all(1'b0);
        #1;
        chk1("pre_start_busy", busy, from_err);
        chk1("pre_start_err", err, from_err);
        @(negedge clk);
        frame_start = 1'b0;
        drive_all(1'b1);
        #1;
        chk1("start_acc_start", acc_start, 1'b1);
        chk1("start_busy", busy, 1'b1);
        chk1("start_err", err, 1'b0);
        chk1("start_stop", stop, 1'b0);
        chk_closed("start");
        @(negedge clk);
        in_idx    = 0;
        out_idx   = 0;
        nobeat    = 0;
        prev_hold = 1'b0;
        src_left  = 0;
        snk_left  = 0;
        src_cool  = 1'b0;
        snk_cool  = 1'b0;
        acc_q.delete();
    endtask

    task automatic run_body();
        bit done_loop;
        bit src_st;
        bit snk_st;
        bit ib;
        bit ob;
        bit exp_open;
        int guard;
        done_loop = 1'b0;
        guard     = 0;
        while (!done_loop && guard < 2000) begin
            guard++;
            if (m_abort >= 0 && out_idx == m_abort) begin
                reset       = 1'b1;
                frame_start = 1'b0;
                drive_all(1'b0);
                @(negedge clk);
                reset = 1'b0;
                drive_all(1'b1);
                #1;
                chk1("abort_busy", busy, 1'b0);
                chk1("abort_stop", stop, 1'b0);
                chk1("abort_acc_start", acc_start, 1'b0);
                chk1("abort_err", err, 1'b0);
                chk_closed("abort");
                repeat (3) begin
                    @(negedge clk);
                    #1;
                    chk1("abort_no_stop", stop, 1'b0);
                    chk1("abort_idle", busy, 1'b0);
                end
                @(negedge clk);
                m_abort   = -1;
                done_loop = 1'b1;
            end else begin
                roll(src_left, src_cool, src_st);
                roll(snk_left, snk_cool, snk_st);
                frame_start       = m_noise ? 1'($urandom_range(0, 1)) : 1'b0;
                sif.src_valid     = (in_idx < SRC_PIX) && !src_st;
                sif.acc_in_ready  = (acc_q.size() < ACC_DEPTH);
                sif.acc_out_valid = (acc_q.size() > 0) && !(m_stuck >= 0 && out_idx >= m_stuck);
                sif.acc_out_data  = sif.acc_out_valid ? acc_q[0] : 8'($urandom);
                sif.snk_ready     = !snk_st;
                #1;
                exp_open = (in_idx < N);
                chk1("src_ready", sif.src_ready, sif.acc_in_ready & exp_open);
                chk1("acc_in_valid", sif.acc_in_valid, sif.src_valid & exp_open);
                chk1("snk_valid", sif.snk_valid, sif.acc_out_valid);
                chk1("acc_out_ready", sif.acc_out_ready, sif.snk_ready);
                chk1("run_acc_start", acc_start, 1'b0);
                chk1("run_busy", busy, 1'b1);
                chk1("run_stop", stop, 1'b0);
                chk1("run_err", err, 1'b0);
                if (sif.snk_valid) begin
                    chk8("snk_data", sif.snk_data, pix(out_idx));
                    chk1("snk_eol", sif.snk_eol, (out_idx % W) == (W - 1));
                    chk1("snk_eof", sif.snk_eof, out_idx == (N - 1));
                end
                if (prev_hold) begin
                    chk1("hold_valid", sif.snk_valid, 1'b1);
                    chk8("hold_data", sif.snk_data, prev_data);
                    chk1("hold_eol", sif.snk_eol, prev_eol);
                    chk1("hold_eof", sif.snk_eof, prev_eof);
                end
                ib        = sif.src_valid & sif.src_ready;
                ob        = sif.snk_valid & sif.snk_ready;
                prev_hold = sif.snk_valid & !sif.snk_ready;
                prev_data = sif.snk_data;
                prev_eol  = sif.snk_eol;
                prev_eof  = sif.snk_eof;
                @(negedge clk);
                if (ob) begin
                    void'(acc_q.pop_front());
                    out_idx++;
                end
                if (ib) begin
                    acc_q.push_back(pix(in_idx));
                    in_idx++;
                end
                nobeat = (ib || ob) ? 0 : nobeat + 1;
                if (ob && out_idx == N) begin
                    frame_start = 1'b0;
                    drive_all(1'b1);
                    #1;
                    chk1("done_stop", stop, 1'b1);
                    chk1("done_busy", busy, 1'b1);
                    chk1("done_err", err, 1'b0);
                    chk1("done_acc_start", acc_start, 1'b0);
                    chk_closed("done");
                    @(negedge clk);
                    #1;
                    chk1("post_stop", stop, 1'b0);
                    chk1("post_busy", busy, 1'b0);
                    @(negedge clk);
                    done_loop = 1'b1;
                end else if (nobeat == TO) begin
                    frame_start = 1'b0;
                    drive_all(1'b1);
                    #1;
                    chk1("wd_err", err, 1'b1);
                    chk1("wd_busy", busy, 1'b1);
                    chk1("wd_stop", stop, 1'b0);
                    chk1("wd_acc_start", acc_start, 1'b0);
                    chk_closed("wd");
                    @(negedge clk);
                    #1;
                    chk1("wd_err_sticky", err, 1'b1);
                    @(negedge clk);
                    done_loop = 1'b1;
                end
            end
        end
        chk1("frame_finished", done_loop, 1'b1);
    endtask

    initial begin
        reset       = 1'b1;
        frame_start = 1'b0;
        drive_all(1'b0);
        m_stall = 1'b0;
        m_noise = 1'b0;
        m_stuck = -1;
        m_abort = -1;
        repeat (3) @(negedge clk);
        drive_all(1'b1);
        #1;
        chk1("reset_busy", busy, 1'b0);
        chk1("reset_acc_start", acc_start, 1'b0);
        chk1("reset_stop", stop, 1'b0);
        chk1("reset_err", err, 1'b0);
        chk1("reset_eol", sif.snk_eol, 1'b0);
        chk_closed("reset");
        @(negedge clk);
        reset = 1'b0;

        // Everything always ready; 8 surplus source pixels must stay unaccepted.
        start_frame(1'b0);
        run_body();
        chki("direct_in_beats", in_idx, N);
        chki("direct_out_beats", out_idx, N);

        // Random source/sink stalls with frame_start noise during RUN.
        m_stall = 1'b1;
        m_noise = 1'b1;
        repeat (6) begin
            start_frame(1'b0);
            run_body();
            chki("rand_in_beats", in_idx, N);
            chki("rand_out_beats", out_idx, N);
        end
        m_stall = 1'b0;
        m_noise = 1'b0;

        // Reset at output beat 6, then a clean frame.
        m_abort = 6;
        start_frame(1'b0);
        run_body();
        chki("abort_out_beats", out_idx, 6);
        start_frame(1'b0);
        run_body();
        chki("after_abort_out_beats", out_idx, N);

        // Accelerator output dies after 5 beats; watchdog trips, then recovery from ERR.
        m_stuck = 5;
        start_frame(1'b0);
        run_body();
        chki("wd_out_beats", out_idx, 5);
        m_stuck = -1;
        start_frame(1'b1);
        run_body();
        chki("recover_out_beats", out_idx, N);
        chki("recover_in_beats", in_idx, N);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
